pe_driver: RTL and testbench
============================

PE_DRIVER -- requirements
Module: pe_driver

Interface
REQ-001 SHALL have parameters: IFMAP_BUS_BITWIDTH, default 8, ifmap beat width; WGHT_BUS_BITWIDTH, default 32, weight beat width; PSUM_BUS_BITWIDTH, default 32, psum beat width; LEN_BITWIDTH, default 8, command beat-count width.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
 i_clk  in  1  single clock, rising edge
 i_rst_n  in  1  asynchronous active-low reset
 i_cmd_opcode  in  3  PE opcode for this command
 i_cmd_len  in  LEN_BITWIDTH  beats to move
 i_cmd_valid / o_cmd_ready  in/out  1  command handshake
 i_src_data  in  WGHT_BUS_BITWIDTH  upstream load data
 i_src_valid / o_src_ready  in/out  1  upstream handshake
 o_snk_data  out  PSUM_BUS_BITWIDTH  downstream drain data
 o_snk_valid / i_snk_ready  out/in  1  downstream handshake
 o_inst_data  out  3  opcode to PE
 o_inst_valid / i_inst_ready  out/in  1  PE instruction handshake
 o_ifmap_data  out  IFMAP_BUS_BITWIDTH  to PE ifmap FIFO
 o_ifmap_valid / i_ifmap_ready  out/in  1
 o_wght_data  out  WGHT_BUS_BITWIDTH  to PE weight FIFO
 o_wght_valid / i_wght_ready  out/in  1
 o_psum_in_data  out  PSUM_BUS_BITWIDTH  to PE psum-in FIFO
 o_psum_in_valid / i_psum_in_ready  out/in  1
 i_psum_out_data  in  PSUM_BUS_BITWIDTH  from PE psum-out FIFO
 i_psum_out_valid / o_psum_out_ready  in/out  1
 o_busy  out  1  high in any state except IDLE
 o_done  out  1  one-cycle pulse at command completion

Function
REQ-003 Handshake transfer ("fire") SHALL occur on a rising edge where valid and ready are both high.
REQ-004 Opcode classes SHALL be: 3'b001 ifmap load, 3'b010 weight load, 3'b011 psum-in load, 3'b101 psum drain; all other codes instruction-only (no data).
REQ-005 FSM states SHALL be IDLE, ISSUE, LOAD, DRAIN, DONE.
REQ-006 IDLE: o_cmd_ready=1; on command fire latch opcode and len, go ISSUE.
REQ-007 ISSUE: o_inst_valid=1, o_inst_data=latched opcode, held stable until i_inst_ready; on fire go LOAD (load class, len!=0), DRAIN (drain class, len!=0), else DONE.
REQ-008 LOAD: only the selected PE port valid SHALL equal i_src_valid; o_src_ready SHALL equal the selected PE port ready; other PE valids 0.
REQ-009 Data SHALL pass combinationally: o_ifmap_data=i_src_data[IFMAP_BUS_BITWIDTH-1:0], o_wght_data=i_src_data, o_psum_in_data=i_src_data, o_snk_data=i_psum_out_data; zero added latency.
REQ-010 DRAIN: o_snk_valid=i_psum_out_valid, o_psum_out_ready=i_snk_ready.
REQ-011 Beat counter (LEN_BITWIDTH) SHALL clear on entry to LOAD/DRAIN and increment on each data fire; fire with counter==len-1 SHALL go DONE.
REQ-012 DONE: o_done=1 for exactly one cycle, then IDLE; o_cmd_ready=0 in DONE.
REQ-013 Outside LOAD, o_src_ready and all PE data valids SHALL be 0; outside DRAIN, o_snk_valid and o_psum_out_ready SHALL be 0; outside ISSUE, o_inst_valid SHALL be 0.
REQ-014 len=2^LEN_BITWIDTH-1 SHALL move exactly that many beats; no counter wrap.
REQ-015 New commands SHALL be refused (o_cmd_ready=0) while o_busy=1; back-to-back minimum command period is 3 cycles for instruction-only.

Reset
REQ-016 i_rst_n low SHALL asynchronously force IDLE, clear counter and latched opcode/len, o_busy=0, o_done=0, o_inst_valid=0, o_inst_data=0, all PE valids 0, o_snk_valid=0, o_psum_out_ready=0, o_src_ready=0, o_cmd_ready=0 while reset asserted.
REQ-017 Reset mid-transfer SHALL abandon the command; no further beats or o_done are produced.

Verification
REQ-018 Weight load: opcode 3'b010, len 4, source words 0x11111111..0x44444444, PE ready always -> one inst fire with data 3'b010, four o_wght fires in order, o_done one cycle after 4th fire.
REQ-019 Ifmap backpressure: opcode 3'b001, len 3, i_ifmap_ready toggled 1/0 -> o_src_ready mirrors i_ifmap_ready, exactly 3 fires, o_ifmap_data = source low bytes.
REQ-020 Drain: opcode 3'b101, len 2, PE psum out 0xDEADBEEF, 0x00000007, i_snk_ready held 0 for 5 cycles -> no fires while held, then both words to sink in order, o_done.
REQ-021 Instruction-only: opcode 3'b100, len 9, i_inst_ready delayed 3 cycles -> o_inst_valid held 3 cycles, no data valids ever asserted, o_done after inst fire.
REQ-022 Zero length: opcode 3'b011, len 0 -> inst issued, no psum-in beats, o_done.
REQ-023 Reset mid-load: assert i_rst_n low after 2 of 5 weight beats -> outputs at reset values immediately, no o_done; new command after release completes normally.

Source files
------------

// File: rtl/pe_driver.sv
// Purpose : sequences one command into a PE: instruction issue, then an optional
//           load (upstream -> PE ifmap/weight/psum-in FIFO) or drain (PE psum-out -> sink).
// Latency : zero-latency combinational data path; one ISSUE cycle plus one DONE cycle per command.
// Backpr. : valid/ready on every port; load/drain beats stall on either side without loss.
//
// Ports:
//   i_clk, i_rst_n                         clock, asynchronous active-low reset
//   i_cmd_opcode/len/valid, o_cmd_ready    command in (accepted only in IDLE)
//   i_src_*  / o_src_ready                 upstream load stream
//   o_snk_*  / i_snk_ready                 downstream drain stream
//   o_inst_* / i_inst_ready                opcode to PE
//   o_ifmap_*, o_wght_*, o_psum_in_*       PE input FIFOs
//   i_psum_out_* / o_psum_out_ready        PE output FIFO
//   o_busy, o_done                         status: not-idle, one-cycle completion pulse
module pe_driver #(
    parameter int IFMAP_BUS_BITWIDTH = 8,
    parameter int WGHT_BUS_BITWIDTH  = 32,
    parameter int PSUM_BUS_BITWIDTH  = 32,
    parameter int LEN_BITWIDTH       = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,

    input  logic [2:0]                    i_cmd_opcode,
    input  logic [LEN_BITWIDTH-1:0]       i_cmd_len,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,

    input  logic [WGHT_BUS_BITWIDTH-1:0]  i_src_data,
    input  logic                          i_src_valid,
    output logic                          o_src_ready,

    output logic [PSUM_BUS_BITWIDTH-1:0]  o_snk_data,
    output logic                          o_snk_valid,
    input  logic                          i_snk_ready,

    output logic [2:0]                    o_inst_data,
    output logic                          o_inst_valid,
    input  logic                          i_inst_ready,

    output logic [IFMAP_BUS_BITWIDTH-1:0] o_ifmap_data,
    output logic                          o_ifmap_valid,
    input  logic                          i_ifmap_ready,

    output logic [WGHT_BUS_BITWIDTH-1:0]  o_wght_data,
    output logic                          o_wght_valid,
    input  logic                          i_wght_ready,

    output logic [PSUM_BUS_BITWIDTH-1:0]  o_psum_in_data,
    output logic                          o_psum_in_valid,
    input  logic                          i_psum_in_ready,

    input  logic [PSUM_BUS_BITWIDTH-1:0]  i_psum_out_data,
    input  logic                          i_psum_out_valid,
    output logic                          o_psum_out_ready,

    output logic                          o_busy,
    output logic                          o_done
);

    localparam logic [2:0] OP_IFMAP   = 3'b001;
    localparam logic [2:0] OP_WGHT    = 3'b010;
    localparam logic [2:0] OP_PSUM_IN = 3'b011;
    localparam logic [2:0] OP_DRAIN   = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              op_q;
    logic [LEN_BITWIDTH-1:0] len_q;
    logic [LEN_BITWIDTH-1:0] cnt_q;
    logic [LEN_BITWIDTH-1:0] len_m1;

    logic sel_ifmap;
    logic sel_wght;
    logic sel_psum_in;
    logic op_is_load;
    logic op_is_drain;
    logic len_nz;
    logic sel_rdy;
    logic cmd_fire;
    logic data_fire;
    logic last_beat;

    // Opcode decode works on the latched copy so the PE-side steering stays
    // stable for the whole command regardless of what the command port does.
    assign sel_ifmap   = (op_q == OP_IFMAP);
    assign sel_wght    = (op_q == OP_WGHT);
    assign sel_psum_in = (op_q == OP_PSUM_IN);
    assign op_is_load  = sel_ifmap | sel_wght | sel_psum_in;
    assign op_is_drain = (op_q == OP_DRAIN);
    assign len_nz      = (len_q != '0);

    assign sel_rdy = (sel_ifmap   & i_ifmap_ready)
                   | (sel_wght    & i_wght_ready)
                   | (sel_psum_in & i_psum_in_ready);

    // len_q >= 1 whenever LOAD/DRAIN is active, so len-1 never underflows there.
    // The counter stops at len-1, so len = 2^LEN_BITWIDTH-1 never wraps it.
    assign len_m1    = len_q - {{(LEN_BITWIDTH-1){1'b0}}, 1'b1};
    assign last_beat = (cnt_q == len_m1);

    assign cmd_fire  = i_cmd_valid & o_cmd_ready;
    assign data_fire = ((state == S_LOAD)  & i_src_valid      & sel_rdy)
                     | ((state == S_DRAIN) & i_psum_out_valid & i_snk_ready);

    // Data buses are straight wires; only the handshakes are steered.
    assign o_ifmap_data   = i_src_data[IFMAP_BUS_BITWIDTH-1:0];
    assign o_wght_data    = i_src_data;
    assign o_psum_in_data = i_src_data;
    assign o_snk_data     = i_psum_out_data;

    // ---------------------------------------------------------------- state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q  <= '0;
            len_q <= '0;
        end else if (cmd_fire) begin
            op_q  <= i_cmd_opcode;
            len_q <= i_cmd_len;
        end
    end

    // Every path into LOAD/DRAIN passes through ISSUE, so clearing there is
    // the same as clearing on entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (state == S_ISSUE) begin
            cnt_q <= '0;
        end else if (data_fire) begin
            cnt_q <= cnt_q + {{(LEN_BITWIDTH-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------ next state + controls
    always_comb begin
        state_nxt        = state;
        o_cmd_ready      = 1'b0;
        o_inst_valid     = 1'b0;
        o_inst_data      = 3'b000;
        o_src_ready      = 1'b0;
        o_ifmap_valid    = 1'b0;
        o_wght_valid     = 1'b0;
        o_psum_in_valid  = 1'b0;
        o_snk_valid      = 1'b0;
        o_psum_out_ready = 1'b0;
        o_busy           = (state != S_IDLE);
        o_done           = 1'b0;

        case (state)
            S_IDLE: begin
                // Gated by reset so the command port reads not-ready while
                // reset is held, even though the state register sits at IDLE.
                o_cmd_ready = i_rst_n;
                if (cmd_fire) begin
                    state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                o_inst_valid = 1'b1;
                o_inst_data  = op_q;
                if (i_inst_ready) begin
                    if (op_is_load && len_nz) begin
                        state_nxt = S_LOAD;
                    end else if (op_is_drain && len_nz) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end

            S_LOAD: begin
                o_src_ready     = sel_rdy;
                o_ifmap_valid   = sel_ifmap   & i_src_valid;
                o_wght_valid    = sel_wght    & i_src_valid;
                o_psum_in_valid = sel_psum_in & i_src_valid;
                if (data_fire && last_beat) begin
                    state_nxt = S_DONE;
                end
            end

            S_DRAIN: begin
                o_snk_valid      = i_psum_out_valid;
                o_psum_out_ready = i_snk_ready;
                if (data_fire && last_beat) begin
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_driver.sv
`timescale 1ns/1ps
module tb_pe_driver;

    localparam int IW = 8;
    localparam int WW = 32;
    localparam int PW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    cmd_opcode = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [WW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic [PW-1:0] snk_data;
    logic          snk_valid;
    logic          snk_ready;
    logic [2:0]    inst_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [IW-1:0] ifmap_data;
    logic          ifmap_valid;
    logic          ifmap_ready;
    logic [WW-1:0] wght_data;
    logic          wght_valid;
    logic          wght_ready;
    logic [PW-1:0] psum_in_data;
    logic          psum_in_valid;
    logic          psum_in_ready;
    logic [PW-1:0] psum_out_data;
    logic          psum_out_valid;
    logic          psum_out_ready;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pe_driver #(
        .IFMAP_BUS_BITWIDTH(IW), .WGHT_BUS_BITWIDTH(WW),
        .PSUM_BUS_BITWIDTH(PW), .LEN_BITWIDTH(LW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_opcode(cmd_opcode), .i_cmd_len(cmd_len),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_src_data(src_data), .i_src_valid(src_valid), .o_src_ready(src_ready),
        .o_snk_data(snk_data), .o_snk_valid(snk_valid), .i_snk_ready(snk_ready),
        .o_inst_data(inst_data), .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
        .o_ifmap_data(ifmap_data), .o_ifmap_valid(ifmap_valid), .i_ifmap_ready(ifmap_ready),
        .o_wght_data(wght_data), .o_wght_valid(wght_valid), .i_wght_ready(wght_ready),
        .o_psum_in_data(psum_in_data), .o_psum_in_valid(psum_in_valid),
        .i_psum_in_ready(psum_in_ready),
        .i_psum_out_data(psum_out_data), .i_psum_out_valid(psum_out_valid),
        .o_psum_out_ready(psum_out_ready),
        .o_busy(busy), .o_done(done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: streams the bench feeds in, and what must come out.
    logic [WW-1:0] src_q[$];
    logic [PW-1:0] pout_q[$];
    logic [WW-1:0] dir_words[$];
    logic [2:0]    exp_inst_q[$];
    logic [IW-1:0] exp_ifm_q[$];
    logic [WW-1:0] exp_wght_q[$];
    logic [PW-1:0] exp_pin_q[$];
    logic [PW-1:0] exp_snk_q[$];

    int         done_cnt = 0;
    int         exp_done = 0;
    int         wght_fires = 0;
    int         inst_vld_cycles = 0;
    int         snk_held_vld = 0;
    logic [2:0] cur_op = 3'b000;
    int         pe_rdy_mode = 0;   // 0 always ready, 1 random, 2 ifmap toggles
    int         src_mode = 0;      // 0 always valid, 1 random
    int         snk_hold = 0;
    int         inst_delay = 0;

    always @(posedge clk) cyc++;

    function automatic bit is_load(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
    endfunction

    function automatic int pending();
        return exp_inst_q.size() + exp_ifm_q.size() + exp_wght_q.size()
             + exp_pin_q.size() + exp_snk_q.size();
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ drivers
    initial begin : src_drv
        bit fire;
        src_valid = 1'b0; src_data = '0;
        forever begin
            @(negedge clk);
            fire = src_valid && src_ready && rst_n;
            @(posedge clk); #1;
            if (fire && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                src_data  = src_q[0];
                src_valid = (src_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                src_data  = $urandom;
                src_valid = 1'b0;
            end
        end
    end

    initial begin : pout_drv
        bit fire;
        psum_out_valid = 1'b0; psum_out_data = '0;
        forever begin
            @(negedge clk);
            fire = psum_out_valid && psum_out_ready && rst_n;
            @(posedge clk); #1;
            if (fire && pout_q.size() > 0) void'(pout_q.pop_front());
            if (pout_q.size() > 0) begin
                psum_out_data  = pout_q[0];
                psum_out_valid = (src_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                psum_out_data  = $urandom;
                psum_out_valid = 1'b0;
            end
        end
    end

    initial begin : rdy_drv
        int iw;
        iw = 0;
        ifmap_ready = 1'b1; wght_ready = 1'b1; psum_in_ready = 1'b1;
        snk_ready = 1'b1; inst_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (pe_rdy_mode)
                1: begin
                    ifmap_ready   = 1'($urandom_range(0, 1));
                    wght_ready    = 1'($urandom_range(0, 1));
                    psum_in_ready = 1'($urandom_range(0, 1));
                end
                2: begin
                    ifmap_ready = ~ifmap_ready;
                    wght_ready = 1'b1; psum_in_ready = 1'b1;
                end
                default: begin
                    ifmap_ready = 1'b1; wght_ready = 1'b1; psum_in_ready = 1'b1;
                end
            endcase
            if (snk_hold > 0) begin
                snk_ready = 1'b0;
                snk_hold--;
            end else begin
                snk_ready = (pe_rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (inst_valid) begin
                if (iw < inst_delay) begin
                    inst_ready = 1'b0;
                    iw++;
                end else begin
                    inst_ready = 1'b1;
                end
            end else begin
                iw = 0;
                inst_ready = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ monitor
    initial begin : monitor
        bit         prev_done;
        bit         prev_wait;
        logic [2:0] prev_inst;
        bit         sel_rdy;
        prev_done = 0; prev_wait = 0; prev_inst = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 0; prev_wait = 0;
                continue;
            end
            if (busy) check("cmd_rdy_while_busy", cmd_ready, 0);

            if (done) begin
                done_cnt++;
                check("done_width", prev_done, 0);
                check("done_with_pending_beats", pending(), 0);
            end
            prev_done = done;

            if (inst_valid) begin
                inst_vld_cycles++;
                if (prev_wait) check("inst_hold_stable", inst_data, prev_inst);
                if (inst_ready) begin
                    if (exp_inst_q.size() == 0) check("inst_unexpected", 1, 0);
                    else check("inst_data", inst_data, exp_inst_q.pop_front());
                end
            end else if (prev_wait) begin
                check("inst_dropped_before_ready", 0, 1);
            end
            prev_wait = inst_valid && !inst_ready;
            prev_inst = inst_data;

            // Steering rules: a PE valid may only appear for the command's
            // class and only echo the source valid; source ready mirrors it.
            case (cur_op)
                3'b001:  sel_rdy = ifmap_ready;
                3'b010:  sel_rdy = wght_ready;
                3'b011:  sel_rdy = psum_in_ready;
                default: sel_rdy = 1'b0;
            endcase
            if (ifmap_valid) begin
                check("ifmap_vld_steer", {cur_op, src_valid, src_ready}, {3'b001, 1'b1, ifmap_ready});
                if (ifmap_ready) begin
                    if (exp_ifm_q.size() == 0) check("ifmap_unexpected", 1, 0);
                    else check("ifmap_data", ifmap_data, exp_ifm_q.pop_front());
                end
            end
            if (wght_valid) begin
                check("wght_vld_steer", {cur_op, src_valid, src_ready}, {3'b010, 1'b1, wght_ready});
                if (wght_ready) begin
                    wght_fires++;
                    if (exp_wght_q.size() == 0) check("wght_unexpected", 1, 0);
                    else check("wght_data", wght_data, exp_wght_q.pop_front());
                end
            end
            if (psum_in_valid) begin
                check("psum_in_vld_steer", {cur_op, src_valid, src_ready}, {3'b011, 1'b1, psum_in_ready});
                if (psum_in_ready) begin
                    if (exp_pin_q.size() == 0) check("psum_in_unexpected", 1, 0);
                    else check("psum_in_data", psum_in_data, exp_pin_q.pop_front());
                end
            end
            if (src_ready) check("src_rdy_steer", {is_load(cur_op), sel_rdy}, 2'b11);
            if (snk_valid) begin
                check("snk_vld_steer", {cur_op, psum_out_valid, psum_out_ready}, {3'b101, 1'b1, snk_ready});
                if (!snk_ready) snk_held_vld++;
                if (snk_ready) begin
                    if (exp_snk_q.size() == 0) check("snk_unexpected", 1, 0);
                    else check("snk_data", snk_data, exp_snk_q.pop_front());
                end
            end
            if (psum_out_ready) check("pout_rdy_steer", {cur_op, snk_ready}, {3'b101, 1'b1});
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic flush_model();
        src_q.delete(); pout_q.delete(); exp_inst_q.delete(); exp_ifm_q.delete();
        exp_wght_q.delete(); exp_pin_q.delete(); exp_snk_q.delete();
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [LW-1:0] len,
                           input bit wait_done, output int fire_cyc);
        logic [WW-1:0] w;
        int            n;
        fire_cyc = -1;
        exp_inst_q.push_back(op);
        for (int i = 0; i < int'(len); i++) begin
            w = (dir_words.size() > 0) ? dir_words.pop_front() : $urandom;
            if (is_load(op)) begin
                src_q.push_back(w);
                case (op)
                    3'b001:  exp_ifm_q.push_back(w[IW-1:0]);
                    3'b010:  exp_wght_q.push_back(w);
                    default: exp_pin_q.push_back(w);
                endcase
            end else if (op == 3'b101) begin
                pout_q.push_back(w);
                exp_snk_q.push_back(w);
            end
        end
        dir_words.delete();
        @(posedge clk); #1;
        cmd_opcode = op; cmd_len = len; cmd_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) break;
            if (++n > 200) begin
                check("cmd_accept_timeout", 0, 1);
                cmd_valid = 1'b0;
                flush_model();
                return;
            end
        end
        cur_op   = op;
        fire_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_opcode = $urandom;
        cmd_len    = $urandom;
        if (!wait_done) return;
        exp_done++;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            if (++n > 3000) begin
                check("done_timeout", 0, 1);
                flush_model();
                return;
            end
        end
        check("beats_left_at_done", pending(), 0);
    endtask

    initial begin : main
        int f1, f2, n;
        // Reset state.
        #12;
        check("rst_outputs",
              {cmd_ready, busy, done, inst_valid, inst_data, src_ready, ifmap_valid,
               wght_valid, psum_in_valid, snk_valid, psum_out_ready},
              '0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", {cmd_ready, busy}, 2'b10);

        // Weight load, fixed words, everything ready.
        pe_rdy_mode = 0; src_mode = 0; inst_delay = 0;
        dir_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_cmd(3'b010, 8'd4, 1, f1);

        // Ifmap load with PE ready toggling every cycle.
        pe_rdy_mode = 2;
        dir_words = '{32'hA1B2C3D4, 32'h0000005A, 32'hFFFFFF00};
        run_cmd(3'b001, 8'd3, 1, f1);
        pe_rdy_mode = 0;

        // Drain with the sink refusing for the first cycles.
        snk_held_vld = 0;
        snk_hold = 6;
        dir_words = '{32'hDEADBEEF, 32'h00000007};
        run_cmd(3'b101, 8'd2, 1, f1);
        check("snk_valid_while_held", snk_held_vld >= 4, 1);

        // Instruction-only with a slow PE instruction port.
        inst_delay = 3;
        inst_vld_cycles = 0;
        run_cmd(3'b100, 8'd9, 1, f1);
        check("inst_valid_cycles", inst_vld_cycles, 4);
        inst_delay = 0;

        // Zero-length load.
        run_cmd(3'b011, 8'd0, 1, f1);

        // Back-to-back instruction-only commands: 3-cycle period.
        run_cmd(3'b000, 8'd5, 1, f1);
        run_cmd(3'b111, 8'd0, 1, f2);
        check("b2b_period", f2 - f1, 3);

        // Maximum length with random backpressure on both sides.
        pe_rdy_mode = 1; src_mode = 1;
        run_cmd(3'b010, 8'd255, 1, f1);

        // Reset in the middle of a weight load.
        pe_rdy_mode = 0; src_mode = 0;
        n = wght_fires;
        run_cmd(3'b010, 8'd5, 0, f1);
        while (wght_fires < n + 2) begin
            @(negedge clk); #1;
            if (cyc > 90000) break;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midload_rst_outputs",
              {cmd_ready, busy, done, inst_valid, inst_data, src_ready, ifmap_valid,
               wght_valid, psum_in_valid, snk_valid, psum_out_ready},
              '0);
        check("midload_beats_before_rst", wght_fires - n, 2);
        flush_model();
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {cmd_ready, busy, done}, 3'b100);
        run_cmd(3'b010, 8'd3, 1, f1);

        // Randomized commands.
        for (int k = 0; k < 30; k++) begin
            logic [2:0]    op;
            logic [LW-1:0] len;
            op  = 3'($urandom_range(0, 7));
            len = LW'($urandom_range(0, 6));
            pe_rdy_mode = $urandom_range(0, 2);
            src_mode    = $urandom_range(0, 1);
            inst_delay  = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) snk_hold = $urandom_range(1, 6);
            run_cmd(op, len, 1, f1);
        end

        repeat (5) @(negedge clk);
        check("done_count", done_cnt, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
